// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched -- DES round-key generator with ready/valid output.
//
// A start pulse in IDLE loads PC1(key_in) into the 56-bit C/D register and
// latches the direction. The block then presents one 48-bit subkey per
// handshake: K1..K16 when encrypting, K16..K1 when decrypting. After the 16th
// key is accepted, done pulses for one cycle and the block returns to IDLE.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   key_in     in  64   DES key, key_in[63] = FIPS bit 1 (parity bits unused)
//   decrypt    in   1   direction, sampled with start
//   start      in   1   begin a new schedule (IDLE only)
//   abort      in   1   cancel a running schedule
//   busy       out  1   schedule in progress (RUN or DONE)
//   rk_valid   out  1   round_key / round_idx valid
//   rk_ready   in   1   consumer accepts the current key
//   round_key  out 48   current subkey, bit 47 = FIPS bit 1
//   round_idx  out  4   position of the current key in the emitted sequence
//   done       out  1   one-cycle pulse after the last key is accepted
// -----------------------------------------------------------------------------

// PC2 selection: 56-bit C/D -> 48-bit subkey. Combinational.
module des_pc2 (
  input  logic [55:0] cd,
  output logic [47:0] k
);
  // FIPS numbering: entry i gives the C/D bit (1 = MSB) for subkey bit i+1.
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  for (genvar i = 0; i < 48; i++) begin : g_sel
    localparam int SRC = 56 - PC2_T[i];
    assign k[47-i] = cd[SRC];
  end

  // C/D bits 9,18,22,25,35,38,43,54 are dropped by PC2.
  logic unused_cd;
  assign unused_cd = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};
endmodule

module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] round_key,
  output logic [3:0]  round_idx,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // PC1: key bit (1 = MSB) feeding each C/D bit, C first.
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  state_t      state, state_nx;
  logic [55:0] cn_dn, cn_dn_nx;
  logic [3:0]  idx, idx_nx;
  logic        dec, dec_nx;
  logic [55:0] pc1_k;
  logic [4:0]  s_pos;
  logic        s_two;

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    localparam int SRC = 64 - PC1_T[i];
    assign pc1_k[55-i] = key_in[SRC];
  end

  // Parity bits (FIPS 8,16,..,64) never reach C/D.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  // Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  function automatic logic two_shift(input logic [4:0] pos);
    return !(pos == 5'd1 || pos == 5'd2 || pos == 5'd9 || pos == 5'd16);
  endfunction

  // 28-bit rotate of one half by 1 or 2 in either direction.
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic right,
                                        input logic two);
    logic [27:0] r;
    case ({right, two})
      2'b00:   r = {x[26:0], x[27]};
      2'b01:   r = {x[25:0], x[27:26]};
      2'b10:   r = {x[0], x[27:1]};
      default: r = {x[1:0], x[27:2]};
    endcase
    return r;
  endfunction

  // Rotation applied when leaving key position idx: encrypt walks forward
  // through the table (next round is idx+2 in 1-based terms), decrypt undoes
  // the shift that produced the current round (16-idx).
  assign s_pos = dec ? (5'd16 - {1'b0, idx}) : ({1'b0, idx} + 5'd2);
  assign s_two = two_shift(s_pos);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cn_dn <= '0;
      idx   <= '0;
      dec   <= 1'b0;
    end else begin
      state <= state_nx;
      cn_dn <= cn_dn_nx;
      idx   <= idx_nx;
      dec   <= dec_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cn_dn_nx = cn_dn;
    idx_nx   = idx;
    dec_nx   = dec;
    case (state)
      IDLE: begin
        // abort alongside start keeps the block idle.
        if (start && !abort) begin
          state_nx = RUN;
          dec_nx   = decrypt;
          idx_nx   = 4'd0;
          // Decrypt starts from C16/D16, which equals PC1 since the total
          // shift is 28; encrypt pre-applies s[1] = 1 to land on C1/D1.
          cn_dn_nx = decrypt ? pc1_k
                             : {rot28(pc1_k[55:28], 1'b0, 1'b0),
                                rot28(pc1_k[27:0],  1'b0, 1'b0)};
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
          idx_nx   = 4'd0;
        end else if (rk_ready) begin
          if (idx == 4'd15) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 4'd1;
            cn_dn_nx = {rot28(cn_dn[55:28], dec, s_two),
                        rot28(cn_dn[27:0],  dec, s_two)};
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 4'd0;
      end
    endcase
  end

  des_pc2 u_pc2 (
    .cd (cn_dn),
    .k  (round_key)
  );

  assign busy      = (state != IDLE);
  assign rk_valid  = (state == RUN);
  assign done      = (state == DONE);
  assign round_idx = idx;
endmodule

// File: doc/des_key_sched.md
DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by DES.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; all state is cleared while low.
REQ-004 key_in  input  64  DES key; key_in[63] = FIPS bit 1; parity bits are ignored.
REQ-005 decrypt  input  1  sampled with start: 0 = emit K1..K16, 1 = emit K16..K1.
REQ-006 start  input  1  request a new schedule; accepted only in IDLE.
REQ-007 abort  input  1  synchronous cancel of a running schedule.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 rk_valid  output  1  round_key and round_idx are valid.
REQ-010 rk_ready  input  1  consumer accepts the current round key.
REQ-011 round_key  output  48  current subkey; bit 47 = FIPS bit 1.
REQ-012 round_idx  output  4  0-based position of the current key in the emitted sequence (0..15).
REQ-013 done  output  1  one-cycle pulse after the 16th key is accepted.

Function
REQ-014 The block SHALL hold a 56-bit C/D register cn_dn, with C = cn_dn[55:28] and D = cn_dn[27:0], and cn_dn[55] = C bit 1.
REQ-015 round_key SHALL be the PC2 selection of cn_dn, produced by an instance of the team's PC2 block; no output register.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: on start=1, cn_dn SHALL load PC1(key_in) with the first-round adjustment applied, decrypt SHALL be latched, round_idx SHALL become 0, and the FSM SHALL go to RUN.
REQ-018 Encrypt first-round adjustment: C and D each rotate left by 1.
REQ-019 Decrypt first-round adjustment: none (PC1 output = C16/D16).
REQ-020 Shift table s[1..16] SHALL be 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-021 RUN: rk_valid SHALL be 1, and round_key, round_idx and cn_dn SHALL hold steady while rk_ready=0.
REQ-022 RUN, on rk_valid & rk_ready with round_idx < 15: round_idx SHALL increment, and C and D SHALL each rotate.
REQ-023 The rotation in REQ-022 SHALL be left by s[round_idx+2] when encrypting and right by s[16-round_idx] when decrypting.
REQ-024 RUN, on a handshake with round_idx = 15: the FSM SHALL go to DONE, and rk_valid SHALL deassert in the next cycle.
REQ-025 DONE SHALL last exactly one cycle, with done=1 and rk_valid=0, then go to IDLE.
REQ-026 Latency: start accepted in cycle T gives rk_valid=1 in T+1.
REQ-027 With rk_ready held at 1, the 16 keys SHALL appear in T+1..T+16, done SHALL pulse in T+17, and a new start SHALL be accepted from T+18.
REQ-028 start in RUN or DONE SHALL be ignored, with no effect on state or latched mode.
REQ-029 abort=1 in RUN or DONE SHALL force IDLE at the next edge, with rk_valid=0, done=0 (no pulse), round_idx=0 and cn_dn held.
REQ-030 abort takes priority over a simultaneous handshake; abort in IDLE SHALL be ignored, and abort together with start in IDLE SHALL leave the block in IDLE.
REQ-031 key_in and decrypt SHALL be don't-care except in the start-accept cycle.
REQ-032 After 16 encrypt rotations the cumulative shift SHALL equal 28, so cn_dn returns to the PC1 value.

Reset
REQ-033 While rst_n=0: state=IDLE, cn_dn=0, round_idx=0, latched decrypt=0, busy=0, rk_valid=0, done=0, and round_key=0.
REQ-034 Reset asserted mid-schedule SHALL abandon it with no done pulse; the first start after rst_n rises SHALL behave as after power-up.

Verification
REQ-035 Encrypt vector: key_in=133457799BBCDFF1, decrypt=0, rk_ready=1 -> idx0 gives 1B02EFFC7072, idx15 gives CB3D8B0E17F5, done in T+17.
REQ-036 Decrypt vector: same key, decrypt=1 -> idx0 gives CB3D8B0E17F5, idx15 gives 1B02EFFC7072; the whole sequence is the exact reverse of REQ-035.
REQ-037 Backpressure: rk_ready random, about 30% high -> key sequence identical to REQ-035; round_key and round_idx stable whenever rk_valid & !rk_ready; exactly 16 handshakes and then one done.
REQ-038 Mid-run events: start pulsed at idx5 -> ignored, sequence unchanged; abort at idx7 -> idle next cycle, no done, and a fresh start gives the correct K1.
REQ-039 Async reset: rst_n low at idx10 -> all outputs 0 immediately, with no clock needed; after release, start gives K1 = 1B02EFFC7072.
REQ-040 Turnaround: back-to-back encrypt then decrypt with start held high -> second start accepted in T+18, and both sequences are correct.
